// File: rtl/ifetcher_pkg.sv
//==============================================================================
// Module : ifetcher_pkg
// Brief  : Shared types and constants for the instruction fetch request path.
// Config : IFETCH_RSP_ERR_EN adds one response-error bit to each buffer entry.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ifetcher_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetchState_t;

  localparam int DEF_PCW = 32;
  localparam int DEF_IW  = 32;

`ifdef IFETCH_RSP_ERR_EN
  localparam int ERR_W = 1;
`else
  localparam int ERR_W = 0;
`endif

  // Buffer entry layout, MSB first: {err (optional), instruction, pc}
  function automatic int entryWidth(input int pcw, input int iw);
    return iw + pcw + ERR_W;
  endfunction

  localparam int ENTRY_W = entryWidth(DEF_PCW, DEF_IW);

endpackage

`default_nettype wire

// File: rtl/ifetcher_req_ctrl_if.sv
//==============================================================================
// Module : ifetcher_req_ctrl_if
// Brief  : PC, memory request/response and decode-side signals of the fetcher.
// Config : IFETCH_RSP_ERR_EN adds iRspErr / oInstErr.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ifetcher_req_ctrl_if
  import ifetcher_pkg::*;
#(
  parameter int PCW = DEF_PCW,
  parameter int IW  = DEF_IW
);

  logic [PCW-1:0] iPC;
  logic           oNext;
  logic           iJumpVld;
  logic           oReqVld;
  logic [PCW-1:0] oReqAddr;
  logic           iReqRdy;
  logic           iRspVld;
  logic [IW-1:0]  iRspData;
  logic           oInstVld;
  logic [IW-1:0]  oInst;
  logic [PCW-1:0] oInstPC;
  logic           iInstRdy;
`ifdef IFETCH_RSP_ERR_EN
  logic           iRspErr;
  logic           oInstErr;
`endif

  // Environment side: PC controller, memory and decode
  modport master (
`ifdef IFETCH_RSP_ERR_EN
    output iRspErr,
    input  oInstErr,
`endif
    output iPC, iJumpVld, iReqRdy, iRspVld, iRspData, iInstRdy,
    input  oNext, oReqVld, oReqAddr, oInstVld, oInst, oInstPC
  );

  // Fetcher side
  modport slave (
`ifdef IFETCH_RSP_ERR_EN
    input  iRspErr,
    output oInstErr,
`endif
    input  iPC, iJumpVld, iReqRdy, iRspVld, iRspData, iInstRdy,
    output oNext, oReqVld, oReqAddr, oInstVld, oInst, oInstPC
  );

endinterface

`default_nettype wire

// File: rtl/ifetcher_inst_buf.sv
//==============================================================================
// Module : ifetcher_inst_buf
// Brief  : Synchronous FIFO with clear, occupancy count and registered head.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ifetcher_inst_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                   iClk,
  input  wire logic                   iResetn,
  input  wire logic                   iPush,
  input  wire logic [WIDTH-1:0]       iPushData,
  input  wire logic                   iPop,
  input  wire logic                   iClear,
  output logic      [WIDTH-1:0]       oHead,
  output logic                        oEmpty,
  output logic      [$clog2(DEPTH):0] oCount
);

  localparam int c_ptrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cntW = $clog2(DEPTH) + 1;
  localparam logic [c_ptrW-1:0] c_lastPtr = c_ptrW'(DEPTH - 1);
  localparam logic [c_cntW-1:0] c_depth   = c_cntW'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_ptrW-1:0] r_rdPtr;
  logic [c_ptrW-1:0] r_wrPtr;
  logic [c_cntW-1:0] r_count;
  logic              w_full;
  logic              w_doPop;
  logic              w_doPush;

  function automatic logic [c_ptrW-1:0] ptrInc(input logic [c_ptrW-1:0] p);
    return (p == c_lastPtr) ? '0 : p + c_ptrW'(1);
  endfunction

  assign w_full   = (r_count == c_depth);
  assign oEmpty   = (r_count == '0);
  // A pop frees the slot first, so a push into a full FIFO is legal alongside it
  assign w_doPop  = iPop && !oEmpty;
  assign w_doPush = iPush && (!w_full || w_doPop);

  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (iClear) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= iPushData;
        r_wrPtr        <= ptrInc(r_wrPtr);
      end
      if (w_doPop) begin
        r_rdPtr <= ptrInc(r_rdPtr);
      end
      r_count <= r_count + c_cntW'(w_doPush) - c_cntW'(w_doPop);
    end
  end

  assign oHead  = r_mem[r_rdPtr];
  assign oCount = r_count;

endmodule

`default_nettype wire

// File: rtl/ifetcher_req_ctrl.sv
//==============================================================================
// Module : ifetcher_req_ctrl
// Brief  : Credit-limited in-order fetch requester with instruction buffer and
//          jump flush of in-flight responses.
// Config : IFETCH_RSP_ERR_EN carries a response-error bit through the buffer.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ifetcher_req_ctrl
  import ifetcher_pkg::*;
#(
  parameter int PCW    = DEF_PCW,
  parameter int IW     = DEF_IW,
  parameter int FDEPTH = 4,
  parameter int OUTSTD = 2
) (
  input wire logic          iClk,
  input wire logic          iResetn,
  ifetcher_req_ctrl_if.slave bus
);

  localparam int c_cntW   = $clog2(FDEPTH) + 1;
  localparam int c_qCntW  = $clog2(OUTSTD) + 1;
  localparam int c_entryW = entryWidth(PCW, IW);
  localparam logic [c_cntW-1:0] c_outstd = c_cntW'(OUTSTD);
  localparam logic [c_cntW:0]   c_fdepth = (c_cntW + 1)'(FDEPTH);

  fetchState_t         r_state;
  fetchState_t         w_stateNext;
  logic [c_cntW-1:0]   r_outst;
  logic [c_cntW-1:0]   w_outstNext;
  logic [c_cntW-1:0]   r_drop;
  logic [c_cntW-1:0]   w_dropNext;

  logic [c_cntW:0]     w_inFlight;
  logic                w_reqVld;
  logic                w_accept;
  logic                w_rspDec;
  logic                w_rspTake;
  logic                w_bufPop;
  logic                w_bufEmpty;
  logic [c_cntW-1:0]   w_bufCount;
  logic [c_entryW-1:0] w_bufHead;
  logic [c_entryW-1:0] w_bufPushData;
  logic [PCW-1:0]      w_pcqHead;
  logic                w_pcqEmpty;
  logic [c_qCntW-1:0]  w_pcqCount;

  // Every request is issued only with a buffer slot reserved for its response
  assign w_inFlight = {1'b0, r_outst} + {1'b0, w_bufCount};
  assign w_reqVld   = iResetn && (r_state == RUN) && !bus.iJumpVld &&
                      (r_outst < c_outstd) && (w_inFlight < c_fdepth);
  assign w_accept   = w_reqVld && bus.iReqRdy;
  assign w_rspDec   = bus.iRspVld && (r_outst != '0);
  assign w_rspTake  = bus.iRspVld && (r_state == RUN) && !bus.iJumpVld;
  assign w_bufPop   = !w_bufEmpty && bus.iInstRdy;

  assign bus.oReqVld  = w_reqVld;
  assign bus.oNext    = w_accept;
  assign bus.oReqAddr = bus.iPC;

`ifdef IFETCH_RSP_ERR_EN
  assign w_bufPushData = {bus.iRspErr, bus.iRspData, w_pcqHead};
  assign bus.oInstErr  = w_bufHead[PCW+IW];
`else
  assign w_bufPushData = {bus.iRspData, w_pcqHead};
`endif

  assign bus.oInstVld = !w_bufEmpty;
  assign bus.oInst    = w_bufHead[PCW +: IW];
  assign bus.oInstPC  = w_bufHead[PCW-1:0];

  ifetcher_inst_buf #(
    .WIDTH (PCW),
    .DEPTH (OUTSTD)
  ) u_pcQueue (
    .iClk      (iClk),
    .iResetn   (iResetn),
    .iPush     (w_accept),
    .iPushData (bus.iPC),
    .iPop      (w_rspTake),
    .iClear    (bus.iJumpVld),
    .oHead     (w_pcqHead),
    .oEmpty    (w_pcqEmpty),
    .oCount    (w_pcqCount)
  );

  ifetcher_inst_buf #(
    .WIDTH (c_entryW),
    .DEPTH (FDEPTH)
  ) u_instBuf (
    .iClk      (iClk),
    .iResetn   (iResetn),
    .iPush     (w_rspTake),
    .iPushData (w_bufPushData),
    .iPop      (w_bufPop),
    .iClear    (bus.iJumpVld),
    .oHead     (w_bufHead),
    .oEmpty    (w_bufEmpty),
    .oCount    (w_bufCount)
  );

  always_comb begin
    w_stateNext = r_state;
    w_outstNext = r_outst;
    w_dropNext  = r_drop;
    case (r_state)
      RUN: begin
        if (bus.iJumpVld) begin
          // A response landing in the jump cycle is already consumed
          w_outstNext = r_outst - c_cntW'(w_rspDec);
          w_dropNext  = w_outstNext;
          w_stateNext = (w_dropNext != '0) ? FLUSH : RUN;
        end else begin
          w_outstNext = r_outst + c_cntW'(w_accept) - c_cntW'(w_rspDec);
        end
      end
      FLUSH: begin
        if (w_rspDec) begin
          w_outstNext = r_outst - c_cntW'(1);
          if (r_drop != '0) begin
            w_dropNext = r_drop - c_cntW'(1);
          end
        end
        w_stateNext = (w_dropNext != '0) ? FLUSH : RUN;
      end
      default: w_stateNext = RUN;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      r_state <= RUN;
      r_outst <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_outst <= w_outstNext;
      r_drop  <= w_dropNext;
    end
  end

  always_ff @(posedge iClk) begin
    if (iResetn) begin
      assert (!(bus.iRspVld && (r_outst == '0)));
      assert (!(w_rspTake && w_pcqEmpty));
      if (r_state == RUN) begin
        assert (c_cntW'(w_pcqCount) == r_outst);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetcher_req_ctrl.sv
//==============================================================================
// Module : tb_ifetcher_req_ctrl
// Brief  : Directed and random stimulus against a queue-based reference model.
// Config : IFETCH_RSP_ERR_EN also checks oInstErr.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ifetcher_req_ctrl;
  import ifetcher_pkg::*;

  localparam int PCW    = 32;
  localparam int IW     = 32;
  localparam int FDEPTH = 4;
  localparam int OUTSTD = 2;

  typedef struct {
    logic [IW-1:0]  inst;
    logic [PCW-1:0] pc;
    bit             err;
  } entry_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ifetcher_req_ctrl_if #(.PCW(PCW), .IW(IW)) bus ();

  ifetcher_req_ctrl #(
    .PCW    (PCW),
    .IW     (IW),
    .FDEPTH (FDEPTH),
    .OUTSTD (OUTSTD)
  ) dut (
    .iClk    (clk),
    .iResetn (rstn),
    .bus     (bus)
  );

  // Reference model state
  entry_t         bufQ[$];
  logic [PCW-1:0] pcQ[$];
  int             outst = 0;
  int             drop = 0;
  bit             flushing = 0;
  // Memory model
  logic [PCW-1:0] pendAddr[$];
  int             pendDue[$];
  bit             pendErr[$];
  int             lastDue = -1;
  // Bookkeeping
  int             total = 0;
  int             bad = 0;
  int             cycle = 0;
  int             acceptCnt = 0;
  int             nextSeen = 0;
  bit             randErr = 0;
  logic [15:0]    seq = '0;
  logic [PCW-1:0] pc = '0;
  logic [PCW-1:0] seenPC[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic cyc(input bit reqRdy, input bit instRdy, input bit jump, input int lat,
                     input logic [PCW-1:0] target);
    bit             rsp, expReq, expNext, expInst, pop, rErr;
    logic [PCW-1:0] rAddr;
    logic [IW-1:0]  rData;
    entry_t         e;
    int             due;

    rsp = (pendDue.size() > 0) && (pendDue[0] <= cycle);
    if (rsp) begin
      rAddr = pendAddr.pop_front();
      void'(pendDue.pop_front());
      rErr  = pendErr.pop_front();
      seq   = seq + 16'd1;
      rData = {rAddr[15:0] ^ 16'hC3A5, seq};
    end else begin
      rAddr = '0;
      rData = IW'($urandom);
      rErr  = 1'($urandom_range(0, 1));
    end

    bus.iPC      = pc;
    bus.iReqRdy  = reqRdy;
    bus.iInstRdy = instRdy;
    bus.iJumpVld = jump;
    bus.iRspVld  = rsp;
    bus.iRspData = rData;
`ifdef IFETCH_RSP_ERR_EN
    bus.iRspErr  = rErr;
`endif
    #1;

    expReq  = !flushing && !jump && (outst < OUTSTD) && (outst + bufQ.size() < FDEPTH);
    expNext = expReq && reqRdy;
    expInst = (bufQ.size() != 0);
    chk("reqVld", 64'(bus.oReqVld), 64'(expReq));
    chk("next", 64'(bus.oNext), 64'(expNext));
    if (expReq) chk("reqAddr", 64'(bus.oReqAddr), 64'(pc));
    chk("instVld", 64'(bus.oInstVld), 64'(expInst));
    if (expInst) begin
      chk("inst", 64'(bus.oInst), 64'(bufQ[0].inst));
      chk("instPC", 64'(bus.oInstPC), 64'(bufQ[0].pc));
`ifdef IFETCH_RSP_ERR_EN
      chk("instErr", 64'(bus.oInstErr), 64'(bufQ[0].err));
`endif
    end
    if (bus.oNext) nextSeen++;
    pop = expInst && instRdy && !jump;
    if (pop && bus.oInstVld) seenPC.push_back(bus.oInstPC);

    if (jump) begin
      bufQ.delete();
      pcQ.delete();
      if (rsp) outst--;
      if (flushing) begin
        if (rsp) drop--;
      end else begin
        drop = outst;
      end
      flushing = (drop != 0);
    end else if (flushing) begin
      if (rsp) begin
        outst--;
        drop--;
      end
      flushing = (drop != 0);
    end else begin
      if (pop) void'(bufQ.pop_front());
      if (rsp) begin
        e.inst = rData;
        e.pc   = pcQ.pop_front();
        e.err  = rErr;
        bufQ.push_back(e);
        outst--;
      end
      if (expNext) begin
        outst++;
        pcQ.push_back(pc);
      end
    end

    if (expNext) begin
      due = cycle + lat;
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      pendAddr.push_back(pc);
      pendDue.push_back(due);
      pendErr.push_back(randErr ? ($urandom_range(0, 3) == 0) : (acceptCnt == 1));
      acceptCnt++;
    end
    if (jump) pc = target;
    else if (expNext) pc = pc + 32'd4;

    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    int n0;
    int idx;
    bit rq, ir, jp;

    bus.iPC      = '0;
    bus.iReqRdy  = 1'b1;
    bus.iInstRdy = 1'b1;
    bus.iJumpVld = 1'b0;
    bus.iRspVld  = 1'b0;
    bus.iRspData = '0;
`ifdef IFETCH_RSP_ERR_EN
    bus.iRspErr  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reqVld", 64'(bus.oReqVld), 64'd0);
    chk("rst_next", 64'(bus.oNext), 64'd0);
    chk("rst_instVld", 64'(bus.oInstVld), 64'd0);
    chk("rst_inst", 64'(bus.oInst), 64'd0);
    chk("rst_instPC", 64'(bus.oInstPC), 64'd0);
`ifdef IFETCH_RSP_ERR_EN
    chk("rst_instErr", 64'(bus.oInstErr), 64'd0);
`endif
    rstn = 1'b1;

    // Streaming, one-cycle memory latency
    repeat (8) cyc(1, 1, 0, 1, '0);
    chk("stream_pc0", 64'(seenPC[0]), 64'h0);
    chk("stream_pc1", 64'(seenPC[1]), 64'h4);
    chk("stream_pc2", 64'(seenPC[2]), 64'h8);

    // Decode stall fills the credit window, then one pop buys one request
    repeat (8) cyc(1, 0, 0, 1, '0);
    bus.iJumpVld = 1'b0;
    bus.iRspVld  = 1'b0;
    #1;
    chk("stall_noReq", 64'(bus.oReqVld), 64'd0);
    n0 = nextSeen;
    cyc(1, 1, 0, 1, '0);
    repeat (4) cyc(1, 0, 0, 1, '0);
    chk("stall_oneReq", 64'(nextSeen - n0), 64'd1);

    // Memory stall, then release
    repeat (6) cyc(1, 1, 0, 1, '0);
    n0 = nextSeen;
    repeat (5) cyc(0, 1, 0, 1, '0);
    chk("memStall_noNext", 64'(nextSeen - n0), 64'd0);
    cyc(1, 1, 0, 1, '0);
    chk("memStall_release", 64'(nextSeen - n0), 64'd1);

    // Jump with two requests still in flight
    repeat (4) cyc(0, 1, 0, 1, '0);
    repeat (2) cyc(1, 1, 0, 3, '0);
    idx = seenPC.size();
    cyc(1, 1, 1, 3, 32'h100);
    repeat (8) cyc(1, 1, 0, 1, '0);
    chk("jump_target", 64'(seenPC[idx]), 64'h100);

    // Jump coincident with a response
    repeat (4) cyc(1, 1, 0, 2, '0);
    cyc(1, 1, 1, 2, 32'h200);
    repeat (6) cyc(1, 1, 0, 2, '0);

    // Second jump while still flushing
    repeat (4) cyc(0, 1, 0, 1, '0);
    repeat (2) cyc(1, 1, 0, 4, '0);
    cyc(1, 1, 1, 4, 32'h280);
    cyc(1, 1, 1, 4, 32'h300);
    repeat (8) cyc(1, 1, 0, 1, '0);

    // Full window with steady simultaneous pop and push
    repeat (6) cyc(1, 0, 0, 1, '0);
    repeat (8) cyc(1, 1, 0, 1, '0);

    // Random traffic
    randErr = 1;
    repeat (400) begin
      rq = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 4) > 1);
      jp = !flushing && ($urandom_range(0, 31) == 0);
      cyc(rq, ir, jp, int'($urandom_range(1, 4)), PCW'($urandom_range(0, 1023)) << 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
